bcd_display_mux: RTL

Downstream consumer of the decade counter: samples its 4-bit units digit every clock, derives tens and hundreds digits by detecting the 9→0 wrap, and time-multiplexes the three digits onto a common-segment seven-segment display. Provides a 000–999 event count, an overflow pulse and a sticky error flag for out-of-range units values.

---
 rtl/bcd_display_mux.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_display_mux.sv
// bcd_display_mux
//   The units digit comes from an upstream decade counter. This block samples
//   it on every clock and builds the tens and hundreds digits by spotting the
//   9->0 wrap. It scans the three digits onto a common-segment seven-segment
//   display.
//
// Parameters
//   REFRESH_DIV    : clock cycles each digit stays lit (2..65535)
//   SEG_ACTIVE_LOW : 1 = seg/an are inverted (0 = lit / selected)
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   din  : units digit, BCD 0..9 (values above 9 are flagged)
//   tens : tens digit, BCD
//   hund : hundreds digit, BCD
//   ovf  : one-cycle pulse on the 999->000 wrap
//   err  : sticky flag, set when din > 9
//   seg  : registered segment pattern, gfedcba order
//   an   : registered one-hot digit select (bit0 units, bit1 tens, bit2 hund)
module bcd_display_mux #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  output logic [3:0] tens,
  output logic [3:0] hund,
  output logic       ovf,
  output logic       err,
  output logic [6:0] seg,
  output logic [2:0] an
);

  typedef enum logic [1:0] {
    SLOT_UNITS = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_HUND  = 2'd2
  } slot_t;

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0]  AN_OFF   = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [6:0]  PAT_DASH  = 7'h40;
  localparam logic [6:0]  PAT_BLANK = 7'h00;

  logic [3:0]  prev;
  logic [15:0] div;
  slot_t       slot, slot_next;
  logic        carry;
  logic [6:0]  pat;
  logic [2:0]  an_hot;

  // Active-high segment pattern for one BCD digit.
  function automatic logic [6:0] digit_pat(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return PAT_DASH;
    endcase
  endfunction

  // Only a true 9->0 step of the upstream counter counts as a decade wrap.
  // This excludes 10->0, 9->9 and 9->1.
  assign carry = (prev == 4'd9) && (din == 4'd0);

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    slot_next = slot;
    pat       = PAT_BLANK;
    an_hot    = 3'b001;
    if (div == DIV_LAST) begin
      case (slot)
        SLOT_UNITS: slot_next = SLOT_TENS;
        SLOT_TENS:  slot_next = SLOT_HUND;
        default:    slot_next = SLOT_UNITS;
      endcase
    end
    // The pattern is built from the current slot and the pre-update digits.
    // The display therefore lags them by one cycle.
    case (slot)
      SLOT_UNITS: begin
        an_hot = 3'b001;
        pat    = (din > 4'd9) ? PAT_DASH : digit_pat(din);
      end
      SLOT_TENS: begin
        an_hot = 3'b010;
        pat    = (hund == 4'd0 && tens == 4'd0) ? PAT_BLANK : digit_pat(tens);
      end
      default: begin
        an_hot = 3'b100;
        pat    = (hund == 4'd0) ? PAT_BLANK : digit_pat(hund);
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // reads the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 4'd0;
      tens <= 4'd0;
      hund <= 4'd0;
      ovf  <= 1'b0;
      err  <= 1'b0;
      div  <= 16'd0;
      slot <= SLOT_UNITS;
      seg  <= SEG_OFF;
      an   <= AN_OFF;
    end else begin
      prev <= din;
      ovf  <= 1'b0;
      if (carry) begin
        if (tens < 4'd9) begin
          tens <= tens + 4'd1;
        end else begin
          tens <= 4'd0;
          if (hund < 4'd9) begin
            hund <= hund + 4'd1;
          end else begin
            hund <= 4'd0;
            ovf  <= 1'b1;
          end
        end
      end
      if (din > 4'd9) err <= 1'b1;
      div  <= (div == DIV_LAST) ? 16'd0 : div + 16'd1;
      slot <= slot_next;
      seg  <= pat ^ {7{SEG_ACTIVE_LOW}};
      an   <= an_hot ^ {3{SEG_ACTIVE_LOW}};
    end
  end

endmodule
